alarma_config: RTL and testbench

Alarm-time programming block for the alarm clock: owns the stored alarm time and the silence flag that the alarm comparator consumes. Two front-panel buttons edit the alarm time in BCD, with an hours/minutes editing state machine and press-and-hold auto-repeat. A third button silences a ringing alarm until the next minute boundary. Outputs drive the comparator's alarm-digit inputs (g0..g3) and its `apagado` input directly.

---
 rtl/alarma_config.sv | 213 +++++++++++++++++++++
 tb/tb_alarma_config.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarma_config.sv
// alarma_config: stores the alarm time (BCD hh:mm) and the silence flag
// consumed by the alarm comparator. Two buttons edit the time through an
// hours/minutes state machine working on a shadow copy with press-and-hold
// auto-repeat. A third button silences the alarm until the next minute tick.
module alarma_config #(
    parameter int HOLD_CYC = 50_000_000,
    parameter int REP_CYC  = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_modo,
    input  logic       btn_inc,
    input  logic       btn_apagar,
    input  logic       tick_min,
    output logic [3:0] g0,
    output logic [3:0] g1,
    output logic [3:0] g2,
    output logic [3:0] g3,
    output logic       apagado,
    output logic       editando,
    output logic       campo
);

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        ED_HORA = 2'd1,
        ED_MIN  = 2'd2
    } state_t;

    // Alarm time as four BCD digits: hours tens/units, minutes tens/units.
    typedef struct packed {
        logic [3:0] h_t;
        logic [3:0] h_u;
        logic [3:0] m_t;
        logic [3:0] m_u;
    } bcd_time_t;

    // Button bit positions inside the conditioning vectors.
    localparam int B_MODO   = 0;
    localparam int B_INC    = 1;
    localparam int B_APAGAR = 2;

    // The hold counter only ever needs to reach the larger of the two limits.
    localparam int CNT_MAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Hours step 00..23 with wrap back to 00.
    function automatic bcd_time_t inc_hours(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.h_t == 4'd2 && t.h_u == 4'd3) begin
            r.h_t = 4'd0;
            r.h_u = 4'd0;
        end else if (t.h_u == 4'd9) begin
            r.h_u = 4'd0;
            r.h_t = t.h_t + 4'd1;
        end else begin
            r.h_u = t.h_u + 4'd1;
        end
        return r;
    endfunction

    // Minutes step 00..59 with wrap back to 00; never carries into hours.
    function automatic bcd_time_t inc_minutes(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.m_u == 4'd9) begin
            r.m_u = 4'd0;
            r.m_t = (t.m_t == 4'd5) ? 4'd0 : t.m_t + 4'd1;
        end else begin
            r.m_u = t.m_u + 4'd1;
        end
        return r;
    endfunction

    logic [2:0]       btn_raw;
    logic [2:0]       s1_q, s2_q, s3_q;
    logic [2:0]       press;
    logic             held_inc;

    state_t           state_q, state_d;
    bcd_time_t        shadow_q, shadow_d;
    bcd_time_t        alarm_q, alarm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rep_q, rep_d;
    logic             apagado_q, apagado_d;

    logic             editing;
    logic [CNT_W-1:0] rep_limit;
    logic             rep_step;
    logic             step;

    assign btn_raw  = {btn_apagar, btn_inc, btn_modo};
    assign press    = s2_q & ~s3_q;
    assign held_inc = s2_q[B_INC];

    // Two-flop synchronizer plus edge register for all three buttons.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values; blocking here would collapse the chain.
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign editing   = (state_q != REPOSO);
    assign rep_limit = rep_q ? CNT_W'(REP_CYC) : CNT_W'(HOLD_CYC);
    assign rep_step  = held_inc && (cnt_q == rep_limit);
    assign step      = editing && (press[B_INC] || rep_step);

    // Next-state, shadow editing, commit and auto-repeat counter.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        shadow_d = shadow_q;
        alarm_d  = alarm_q;
        cnt_d    = '0;
        rep_d    = 1'b0;

        // Hold counter: counts held cycles, reloads to 1 on each repeat step
        // and switches the limit from the initial delay to the repeat period.
        if (editing && held_inc) begin
            if (rep_step) begin
                cnt_d = CNT_W'(1);
                rep_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                rep_d = rep_q;
            end
        end

        unique case (state_q)
            REPOSO: begin
                if (press[B_MODO]) begin
                    state_d  = ED_HORA;
                    shadow_d = alarm_q;
                    cnt_d    = '0;
                    rep_d    = 1'b0;
                end
            end
            ED_HORA: begin
                // Mode wins over a simultaneous step; the step is dropped.
                if (press[B_MODO]) begin
                    state_d = ED_MIN;
                    cnt_d   = '0;
                    rep_d   = 1'b0;
                end else if (step) begin
                    shadow_d = inc_hours(shadow_q);
                end
            end
            ED_MIN: begin
                if (press[B_MODO]) begin
                    state_d = REPOSO;
                    alarm_d = shadow_q;
                    cnt_d   = '0;
                    rep_d   = 1'b0;
                end else if (step) begin
                    shadow_d = inc_minutes(shadow_q);
                end
            end
            default: begin
                state_d = REPOSO;
                cnt_d   = '0;
                rep_d   = 1'b0;
            end
        endcase
    end

    // Silence flag: the minute tick has priority over a silence press.
    always_comb begin
        apagado_d = apagado_q;
        if (tick_min) begin
            apagado_d = 1'b0;
        end else if (press[B_APAGAR]) begin
            apagado_d = 1'b1;
        end
    end

    // State, shadow, committed alarm, counter and silence registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= REPOSO;
            shadow_q  <= '0;
            alarm_q   <= '0;
            cnt_q     <= '0;
            rep_q     <= 1'b0;
            apagado_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            alarm_q   <= alarm_d;
            cnt_q     <= cnt_d;
            rep_q     <= rep_d;
            apagado_q <= apagado_d;
        end
    end

    assign g0       = alarm_q.m_u;
    assign g1       = alarm_q.m_t;
    assign g2       = alarm_q.h_u;
    assign g3       = alarm_q.h_t;
    assign apagado  = apagado_q;
    assign editando = editing;
    assign campo    = (state_q == ED_MIN);

endmodule

// File: tb/tb_alarma_config.sv
// Testbench for alarma_config: a table of single-operation vectors with
// hand-computed outputs, plus directed sequences for multi-cycle corners.
module tb_alarma_config;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_modo = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_apagar = 1'b0;
    logic       tick_min = 1'b0;
    logic [3:0] g0, g1, g2, g3;
    logic       apagado, editando, campo;

    int n_total  = 0;
    int n_passed = 0;

    alarma_config #(.HOLD_CYC(8), .REP_CYC(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_modo   (btn_modo),
        .btn_inc    (btn_inc),
        .btn_apagar (btn_apagar),
        .tick_min   (tick_min),
        .g0         (g0),
        .g1         (g1),
        .g2         (g2),
        .g3         (g3),
        .apagado    (apagado),
        .editando   (editando),
        .campo      (campo)
    );

    always #5 clk = ~clk;

    typedef enum int {OP_RESET, OP_MODO, OP_INC, OP_APAGAR, OP_TICK} op_e;

    // One vector: operation, then expected {g3,g2,g1,g0}, editando, campo, apagado.
    typedef struct {
        op_e         op;
        logic [15:0] g;
        logic        ed;
        logic        ca;
        logic        ap;
    } vec_t;

    vec_t vecs [16];

    function automatic logic [15:0] gval();
        return {g3, g2, g1, g0};
    endfunction

    function automatic logic [15:0] bcd(input int h, input int m);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_passed++;
        end
    endtask

    // Advance n clock edges, leaving time 1 unit past the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise one button for one sampled edge; returns once its effect is visible.
    task automatic press(input int b);
        case (b)
            0: btn_modo = 1'b1;
            1: btn_inc = 1'b1;
            default: btn_apagar = 1'b1;
        endcase
        tick(1);
        btn_modo = 1'b0;
        btn_inc = 1'b0;
        btn_apagar = 1'b0;
        tick(2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

    task automatic pulse_tick();
        tick_min = 1'b1;
        tick(1);
        tick_min = 1'b0;
    endtask

    task automatic apply(input op_e op);
        case (op)
            OP_RESET:  do_reset();
            OP_MODO:   press(0);
            OP_INC:    press(1);
            OP_APAGAR: press(2);
            default:   pulse_tick();
        endcase
    endtask

    // From a fresh reset, enter ED_MIN after h hour steps and m minute steps.
    task automatic edit_to(input int h, input int m);
        press(0);
        repeat (h) press(1);
        press(0);
        repeat (m) press(1);
    endtask

    // Reset, enter ED_MIN at 00, hold inc for n edges, commit, check minutes.
    task automatic hold_case(input string name, input int n, input int exp_min);
        do_reset();
        press(0);
        press(0);
        btn_inc = 1'b1;
        tick(n);
        btn_inc = 1'b0;
        tick(3);
        press(0);
        check(name, gval(), bcd(0, exp_min));
    endtask

    initial begin
        vecs[0]  = '{OP_RESET,  16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{OP_INC,    16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{OP_MODO,   16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{OP_INC,    16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{OP_INC,    16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{OP_MODO,   16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{OP_INC,    16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{OP_MODO,   16'h0201, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{OP_APAGAR, 16'h0201, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{OP_TICK,   16'h0201, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{OP_MODO,   16'h0201, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{OP_INC,    16'h0201, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{OP_MODO,   16'h0201, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{OP_APAGAR, 16'h0201, 1'b1, 1'b1, 1'b1};
        vecs[14] = '{OP_MODO,   16'h0301, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{OP_TICK,   16'h0301, 1'b0, 1'b0, 1'b0};

        tick(2);
        rst_n = 1'b1;

        // Table-driven single operations.
        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].op);
            check($sformatf("vec%0d g", i), gval(), vecs[i].g);
            check($sformatf("vec%0d editando", i), editando, vecs[i].ed);
            check($sformatf("vec%0d campo", i), campo, vecs[i].ca);
            check($sformatf("vec%0d apagado", i), apagado, vecs[i].ap);
        end

        // Hours wrap: 24 single steps, each committed, g holds until commit.
        do_reset();
        for (int i = 1; i <= 24; i++) begin
            press(0);
            press(1);
            check($sformatf("hwrap%0d hold", i), gval(), bcd(i - 1, 0));
            press(0);
            press(0);
            check($sformatf("hwrap%0d commit", i), gval(), bcd(i % 24, 0));
        end

        // Minutes carry: 07:59 -> 07:00, commit lands with editando falling.
        do_reset();
        edit_to(7, 59);
        check("m59 precommit", gval(), 16'h0000);
        btn_modo = 1'b1;
        tick(1);
        btn_modo = 1'b0;
        tick(1);
        check("m59 edge-1 ed", editando, 1'b1);
        check("m59 edge-1 g", gval(), 16'h0000);
        tick(1);
        check("m59 commit ed", editando, 1'b0);
        check("m59 commit g", gval(), 16'h0759);
        press(0);
        press(0);
        press(1);
        check("mcarry hold", gval(), 16'h0759);
        btn_modo = 1'b1;
        tick(1);
        btn_modo = 1'b0;
        tick(1);
        check("mcarry edge-1 ed", editando, 1'b1);
        tick(1);
        check("mcarry commit ed", editando, 1'b0);
        check("mcarry commit g", gval(), 16'h0700);

        // Auto-repeat boundaries (HOLD_CYC=8, REP_CYC=3).
        hold_case("hold8", 8, 1);
        hold_case("hold9", 9, 2);
        hold_case("hold10", 10, 2);
        hold_case("hold20", 20, 5);
        hold_case("hold23", 23, 6);
        // Release between two short holds clears the counter.
        do_reset();
        press(0);
        press(0);
        btn_inc = 1'b1;
        tick(5);
        btn_inc = 1'b0;
        tick(3);
        btn_inc = 1'b1;
        tick(5);
        btn_inc = 1'b0;
        tick(3);
        press(0);
        check("hold5+5", gval(), bcd(0, 2));

        // Silence: set three edges after raw press, cleared by tick_min.
        do_reset();
        btn_apagar = 1'b1;
        tick(1);
        btn_apagar = 1'b0;
        tick(1);
        check("sil edge2", apagado, 1'b0);
        tick(1);
        check("sil edge3", apagado, 1'b1);
        tick(10);
        check("sil hold", apagado, 1'b1);
        pulse_tick();
        check("sil tick", apagado, 1'b0);
        // Press and tick on the same edge: tick wins.
        btn_apagar = 1'b1;
        tick(1);
        btn_apagar = 1'b0;
        tick(1);
        tick_min = 1'b1;
        tick(1);
        tick_min = 1'b0;
        check("sil collide", apagado, 1'b0);
        tick(2);
        check("sil collide later", apagado, 1'b0);
        // A held button presses only once; tick during the hold clears it.
        btn_apagar = 1'b1;
        tick(3);
        check("sil held set", apagado, 1'b1);
        pulse_tick();
        tick(2);
        check("sil held cleared", apagado, 1'b0);
        btn_apagar = 1'b0;
        tick(2);

        // Mode/inc collision in ED_MIN at 12:34: commit drops the step.
        do_reset();
        edit_to(12, 34);
        btn_modo = 1'b1;
        btn_inc = 1'b1;
        tick(1);
        btn_modo = 1'b0;
        btn_inc = 1'b0;
        tick(2);
        check("collide g", gval(), 16'h1234);
        check("collide ed", editando, 1'b0);

        // Reset mid-edit discards the shadow and the committed time.
        press(2);
        press(0);
        press(0);
        press(1);
        check("rstmid pre ed", editando, 1'b1);
        check("rstmid pre ap", apagado, 1'b1);
        do_reset();
        check("rstmid g", gval(), 16'h0000);
        check("rstmid ed", editando, 1'b0);
        check("rstmid campo", campo, 1'b0);
        check("rstmid ap", apagado, 1'b0);
        press(0);
        press(0);
        press(0);
        check("rstmid recommit", gval(), 16'h0000);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
